// File: rtl/mul_arb.sv
// mul_arb: round-robin sharing of one combinational XLEN x XLEN multiplier between two issue lanes.
// Define MUL_ARB_STATS_EN to add the stat_busy / stat_conflict activity counters.
`timescale 1ns/1ps

module mul_arb #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][1:0]      req_op,
  input  logic [1:0][XLEN-1:0] req_rdata1,
  input  logic [1:0][XLEN-1:0] req_rdata2,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [1:0][XLEN-1:0] resp_result,
  output logic [XLEN-1:0]      mul_rdata1,
  output logic [XLEN-1:0]      mul_rdata2,
  output logic [3:0]           mul_op,
  input  logic [XLEN-1:0]      mul_result
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [31:0]          stat_busy,
  output logic [31:0]          stat_conflict
`endif
);

  logic       s1_valid;
  logic       s1_lane;
  logic       ptr;
  logic [1:0] outstanding;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       grant_lane;

  // A lane is busy while its op sits in stage 1 or its result waits unconsumed.
  always_comb begin
    outstanding    = 2'b00;
    outstanding[0] = (s1_valid & ~s1_lane) | (resp_valid[0] & ~resp_ready[0]);
    outstanding[1] = (s1_valid &  s1_lane) | (resp_valid[1] & ~resp_ready[1]);
    eligible       = req_valid & ~outstanding & {2{~flush & ~rst}};
    grant          = eligible;
    if (&eligible) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
    grant_lane = grant[1];
  end

  assign req_ready = grant;

  // Stage 1 operand register, pointer, and per-lane response buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 1'(PRIO_INIT);
      s1_valid    <= 1'b0;
      s1_lane     <= 1'b0;
      mul_rdata1  <= '0;
      mul_rdata2  <= '0;
      mul_op      <= 4'b0000;
      resp_valid  <= 2'b00;
      resp_result <= '0;
    end else begin
      s1_valid <= |grant;
      if (|grant) begin
        ptr        <= ~grant_lane;
        s1_lane    <= grant_lane;
        mul_rdata1 <= req_rdata1[grant_lane];
        mul_rdata2 <= req_rdata2[grant_lane];
        mul_op     <= 4'b0001 << req_op[grant_lane];
      end
      for (int i = 0; i < 2; i++) begin
        if (flush) begin
          resp_valid[i] <= 1'b0;
        end else if (s1_valid && (s1_lane == 1'(i))) begin
          resp_valid[i]  <= 1'b1;
          resp_result[i] <= mul_result;
        end else if (resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef MUL_ARB_STATS_EN
  // Free-running activity counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_busy     <= 32'd0;
      stat_conflict <= 32'd0;
    end else begin
      if (s1_valid) begin
        stat_busy <= stat_busy + 32'd1;
      end
      if (&eligible) begin
        stat_conflict <= stat_conflict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul_arb.sv
// Randomised scoreboard bench for mul_arb; a behavioural multiplier stands in for the mul unit.
`timescale 1ns/1ps

module tb_mul_arb;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned PRIO_INIT = 0;

  logic                 clk = 1'b0;
  logic                 rst, flush;
  logic [1:0]           req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0][1:0]      req_op;
  logic [1:0][XLEN-1:0] req_rdata1, req_rdata2, resp_result;
  logic [XLEN-1:0]      mul_rdata1, mul_rdata2, mul_result;
  logic [3:0]           mul_op;
`ifdef MUL_ARB_STATS_EN
  logic [31:0]          stat_busy, stat_conflict;
  int unsigned          m_busy, m_conf;
  bit                   last_g;
`endif

  always #5 clk = ~clk;

  mul_arb #(.XLEN(XLEN), .PRIO_INIT(PRIO_INIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rdata1(req_rdata1), .req_rdata2(req_rdata2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .mul_rdata1(mul_rdata1), .mul_rdata2(mul_rdata2), .mul_op(mul_op),
    .mul_result(mul_result)
`ifdef MUL_ARB_STATS_EN
    , .stat_busy(stat_busy), .stat_conflict(stat_conflict)
`endif
  );

  typedef struct {
    logic [XLEN-1:0] res;
    int              acc;
  } exp_t;

  exp_t sb[2][$];
  bit   seen[2];
  bit   ptr;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RISC-V M semantics from sign/zero extension and a double-width product.
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ea, eb, p;
    ea = (op == 2'b11) ? {{XLEN{1'b0}}, a} : {{XLEN{a[XLEN-1]}}, a};
    eb = op[1] ? {{XLEN{1'b0}}, b} : {{XLEN{b[XLEN-1]}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    mul_result = '0;
    case (mul_op)
      4'b0001: mul_result = ref_mul(2'b00, mul_rdata1, mul_rdata2);
      4'b0010: mul_result = ref_mul(2'b01, mul_rdata1, mul_rdata2);
      4'b0100: mul_result = ref_mul(2'b10, mul_rdata1, mul_rdata2);
      4'b1000: mul_result = ref_mul(2'b11, mul_rdata1, mul_rdata2);
      default: mul_result = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Arbitration model: a lane is free once it has nothing pending, or its
  // result is in the buffer and being consumed this cycle.
  task automatic issue_check();
    logic [1:0] el, g;
    bit         busy, lane;
    exp_t       e;
    for (int i = 0; i < 2; i++) begin
      busy  = (sb[i].size() != 0) && !((cyc >= sb[i][0].acc + 2) && resp_ready[i]);
      el[i] = req_valid[i] && !busy && !flush && !rst;
    end
    g = el;
    if (el == 2'b11) g = ptr ? 2'b10 : 2'b01;
    chk("req_ready", 64'(req_ready), 64'(g));
`ifdef MUL_ARB_STATS_EN
    if (mon_en) begin
      chk("stat_busy", 64'(stat_busy), 64'(m_busy));
      chk("stat_conflict", 64'(stat_conflict), 64'(m_conf));
    end
    if (rst) begin
      m_busy = 0;
      m_conf = 0;
    end else begin
      if (last_g) m_busy++;
      if (el == 2'b11) m_conf++;
    end
    last_g = (g != 2'b00);
`endif
    if (rst) begin
      ptr = 1'(PRIO_INIT);
    end else if (g != 2'b00) begin
      lane  = g[1];
      ptr   = ~lane;
      e.res = ref_mul(req_op[lane], req_rdata1[lane], req_rdata2[lane]);
      e.acc = cyc;
      sb[lane].push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    issue_check();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: latency, value, stability and absence of stray responses.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (sb[i].size() == 0) begin
          chk($sformatf("resp_spurious%0d", i), 64'(resp_valid[i]), 64'd0);
        end else if (resp_valid[i]) begin
          if (!seen[i]) begin
            chk($sformatf("resp_latency%0d", i), 64'(cyc), 64'(sb[i][0].acc + 2));
            seen[i] = 1'b1;
          end
          chk($sformatf("resp_result%0d", i), 64'(resp_result[i]), 64'(sb[i][0].res));
          if (resp_ready[i]) begin
            void'(sb[i].pop_front());
            seen[i] = 1'b0;
          end
        end else if (cyc >= sb[i][0].acc + 2) begin
          chk($sformatf("resp_missing%0d", i), 64'(resp_valid[i]), 64'd1);
        end
      end
      if (flush || rst) begin
        for (int i = 0; i < 2; i++) begin
          sb[i].delete();
          seen[i] = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int lane, input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
    req_op[lane]     = op;
    req_rdata1[lane] = a;
    req_rdata2[lane] = b;
  endtask

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(XLEN-1){1'b0}}};
      3:       return XLEN'(1);
      default: return XLEN'($urandom);
    endcase
  endfunction

  task automatic reset_checks();
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    chk("rst_mul_op", 64'(mul_op), 64'd0);
    chk("rst_mul_rdata1", 64'(mul_rdata1), 64'd0);
    chk("rst_mul_rdata2", 64'(mul_rdata2), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
    req_op = '0; req_rdata1 = '0; req_rdata2 = '0;
    ptr = 1'(PRIO_INIT);
    step();
    step();
    mon_en = 1'b1;
    reset_checks();
    rst = 1'b0;

    // Single lane-0 multiply.
    set_req(0, 2'b00, 32'h3, 32'h5);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    repeat (3) step();

    // Both lanes together straight after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_req(1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 2'b11;
    step();
    step();
    req_valid = 2'b00;
    repeat (3) step();

    // mulhsu corner.
    set_req(0, 2'b10, 32'hFFFF_FFFF, 32'h2);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    repeat (3) step();

    // Lane 0 back-pressured while lane 1 keeps issuing.
    resp_ready = 2'b10;
    set_req(0, 2'b00, 32'h1234_5678, 32'h9);
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      set_req(1, 2'($urandom), pick(), pick());
      step();
    end
    resp_ready = 2'b11;
    req_valid  = 2'b01;
    set_req(0, 2'b11, 32'hDEAD_BEEF, 32'h1_0000);
    step();
    req_valid = 2'b00;
    repeat (3) step();

    // Flush kills lane 1's op in stage 1, then lane 1 issues again.
    set_req(1, 2'b00, 32'hAAAA_5555, 32'h3);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    set_req(1, 2'b00, 32'd7, 32'd6);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    repeat (3) step();

    // Reset with stage 1 and lane-0 buffer both occupied.
    resp_ready = 2'b00;
    set_req(0, 2'b00, 32'd11, 32'd13);
    req_valid = 2'b01;
    step();
    set_req(1, 2'b00, 32'd17, 32'd19);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    reset_checks();
    rst = 1'b0;
    resp_ready = 2'b11;
    req_valid = 2'b11;
    step();
    req_valid = 2'b00;
    repeat (3) step();

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 800; k++) begin
      req_valid = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        set_req(i, 2'($urandom), pick(), pick());
        resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      flush = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end

    rst = 1'b0; flush = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
    repeat (6) step();
    chk("drain", 64'(sb[0].size() + sb[1].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_arb.md
Name: mul_arb

Overview:
- Shares the single combinational 32-bit multiplier between the two issue lanes of the dual-issue execute stage.
- Round-robin arbitration between lane requests.
- Registers the granted operands, drives the multiplier, and captures its result into a per-lane response buffer with valid/ready handshake.
- Sits between the issue/execute lanes and the mul unit; supports pipeline flush.

Parameters:
XLEN, 32, operand/result width (multiplier is XLEN x XLEN)
PRIO_INIT, 0, lane holding round-robin priority after reset (0 or 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  kill all in-flight and buffered ops
req_valid  in  2  per-lane request valid
req_ready  out  2  per-lane request accepted this cycle
req_op  in  2x2  per-lane op: 00 mul(low), 01 mulh, 10 mulhsu, 11 mulhu
req_rdata1  in  2xXLEN  per-lane operand 1
req_rdata2  in  2xXLEN  per-lane operand 2
resp_valid  out  2  per-lane result valid
resp_ready  in  2  per-lane result consumed
resp_result  out  2xXLEN  per-lane result
mul_rdata1  out  XLEN  operand 1 to multiplier
mul_rdata2  out  XLEN  operand 2 to multiplier
mul_op  out  4  one-hot {mulhu,mulhsu,mulh,muls} to multiplier
mul_result  in  XLEN  multiplier result (combinational from mul_*)

Behaviour:
- Reset (rst=1 at clk edge):
  - s1_valid=0, buffers empty, resp_valid=0, resp_result=0.
  - mul_rdata1/2=0, mul_op=0 (muls bit clear).
  - Priority pointer = PRIO_INIT.
  - req_ready=0 while rst is high.
- Outstanding per lane:
  - outstanding[i] = (s1_valid & s1_lane==i) | (buf_valid[i] & ~resp_ready[i]).
  - Each lane has at most one op in flight.
  - eligible[i] = req_valid[i] & ~outstanding[i] & ~flush & ~rst.
- Arbitration, combinational:
  - Exactly one eligible lane: it is granted.
  - Both eligible: the lane at the pointer is granted.
  - req_ready = grant; at most one bit is set per cycle.
- Pointer update on any grant: pointer = ~granted lane. No grant: pointer holds.
- Stage 1 (operand register):
  - On a grant at edge E0: s1_valid=1, s1_lane, operands and op are registered.
  - mul_* outputs come straight from the stage-1 registers.
  - mul_op is decoded one-hot from the 2-bit op.
  - s1_valid clears at the next edge if no new grant occurs.
- Stage 2 (response buffer):
  - At edge E1 (after E0), if s1_valid: buf[s1_lane] = mul_result and buf_valid=1.
  - Latency: request accepted in cycle N gives resp_valid in cycle N+2.
- Response handshake:
  - resp_valid[i] = buf_valid[i]; resp_result[i] holds stable until resp_valid & resp_ready.
  - On consume, buf_valid clears unless a new capture for that lane occurs at the same edge; the capture wins.
  - A lane whose buffer drains in cycle N may be granted again in cycle N (back-to-back, no bubble).
- Flush:
  - At the flush edge: s1_valid=0 and all buf_valid=0; no response is produced for killed ops.
  - req_ready=0 during the flush cycle; pointer holds.
  - Flush while an op is in stage 1: its result is discarded, not captured.
- Throughput: one op per cycle total. A lane can accept at most one op every 2 cycles, limited by the outstanding rule.

Optional Feature:
- Macro: MUL_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_busy (32) and stat_conflict (32); both reset to 0.
  - stat_busy increments every cycle s1_valid=1.
  - stat_conflict increments every cycle both lanes are eligible.
  - Both counters wrap at 2^32-1 to 0 and are unaffected by flush.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Lane0 only, op=00, a=0x00000003, b=0x00000005, accepted cycle N -> resp_valid[0] in N+2 with result 0x0000000F; lane1 resp_valid stays 0.
2. Both lanes request in the same cycle after reset (PRIO_INIT=0):
   - lane0 op=01, a=0xFFFFFFFF, b=0xFFFFFFFF; lane1 op=11, same operands.
   - Lane0 is granted first -> result 0x00000000.
   - Lane1 is granted the next cycle -> result 0xFFFFFFFE.
3. op=10, a=0xFFFFFFFF, b=0x00000002 -> result 0xFFFFFFFF.
4. Backpressure:
   - Lane0 resp_ready=0 for 5 cycles -> resp_result held stable; req_ready[0]=0 meanwhile.
   - Lane1 is still granted each eligible cycle.
   - When resp_ready[0]=1, lane0 is re-granted in that same cycle.
5. Flush in the cycle after lane1's acceptance -> no resp_valid[1] ever for that op; next lane1 request (a=7, b=6, op=00) returns 0x0000002A.
6. rst asserted mid-operation (s1_valid=1, buf_valid[0]=1) -> next cycle all resp_valid=0, req_ready=0 during rst, pointer=PRIO_INIT; with MUL_ARB_STATS_EN the counters read 0.
